// File: rtl/udp_word_tx.sv
// Word-to-UDP packetizer: buffers 32-bit words and emits them big-endian as an
// 8-bit AXI-Stream payload behind a UDP header handshake.
module udp_word_tx #(
  parameter int FIFO_DEPTH   = 16,
  parameter int PKT_WORDS    = 4,
  parameter int FLUSH_CYCLES = 1250
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [31:0]                   in_data,
  input  logic                          in_valid,
  output logic                          in_ready,
  output logic                          tx_udp_hdr_valid,
  input  logic                          tx_udp_hdr_ready,
  output logic [15:0]                   tx_udp_length,
  output logic [7:0]                    tx_udp_payload_axis_tdata,
  output logic                          tx_udp_payload_axis_tvalid,
  input  logic                          tx_udp_payload_axis_tready,
  output logic                          tx_udp_payload_axis_tlast,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic [15:0]                   pkt_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int FW = (FLUSH_CYCLES > 1) ? $clog2(FLUSH_CYCLES) : 1;

  typedef enum logic [1:0] {IDLE, HDR, PAYLOAD} state_t;

  state_t        state, state_next;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [LW-1:0] n_words, word_cnt, n_start;
  logic [1:0]    byte_idx;
  logic [FW-1:0] flush_cnt;
  logic          wr_en, hs, pop, last_hs, partial, flush_exp, start;
  logic          hdr_valid_d, tvalid_d, tlast_d;
  logic [7:0]    tdata_d;
  logic [31:0]   head_word, next_word;

  function automatic logic [7:0] sel_byte(input logic [31:0] w, input logic [1:0] b);
    case (b)
      2'd0:    return w[31:24];
      2'd1:    return w[23:16];
      2'd2:    return w[15:8];
      default: return w[7:0];
    endcase
  endfunction

  assign in_ready  = (fifo_level != LW'(FIFO_DEPTH));
  assign wr_en     = in_valid & in_ready;
  assign hs        = tx_udp_payload_axis_tvalid & tx_udp_payload_axis_tready;
  assign pop       = hs & (byte_idx == 2'd3);
  assign last_hs   = hs & tx_udp_payload_axis_tlast;
  assign partial   = (fifo_level != '0) && (fifo_level < LW'(PKT_WORDS));
  assign flush_exp = (FLUSH_CYCLES != 0) && partial && (flush_cnt == FW'(FLUSH_CYCLES - 1));
  assign start     = (state == IDLE) && ((fifo_level >= LW'(PKT_WORDS)) || flush_exp);
  assign n_start   = (fifo_level >= LW'(PKT_WORDS)) ? LW'(PKT_WORDS) : fifo_level;
  assign head_word = mem[rd_ptr];
  assign next_word = mem[rd_ptr + 1'b1];

  // NOTE: the word storage has no reset; only pointers and level define its contents.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start) state_next = HDR;
      HDR:     if (tx_udp_hdr_ready) state_next = PAYLOAD;
      PAYLOAD: if (last_hs) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Next values of the registered stream outputs; tdata is preloaded so the
  // byte on the bus always matches byte_idx/word_cnt.
  always_comb begin
    hdr_valid_d = (state_next == HDR);
    tvalid_d    = (state_next == PAYLOAD);
    tdata_d     = tx_udp_payload_axis_tdata;
    tlast_d     = tx_udp_payload_axis_tlast;
    if (state == HDR && tx_udp_hdr_ready) begin
      tdata_d = head_word[31:24];
      tlast_d = 1'b0;
    end else if (state == PAYLOAD && hs) begin
      if (tx_udp_payload_axis_tlast) begin
        tdata_d = 8'h00;
        tlast_d = 1'b0;
      end else if (byte_idx == 2'd3) begin
        tdata_d = next_word[31:24];
        tlast_d = 1'b0;
      end else begin
        tdata_d = sel_byte(head_word, 2'(byte_idx + 2'd1));
        tlast_d = (byte_idx == 2'd2) && (word_cnt == n_words - 1'b1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr                     <= '0;
      rd_ptr                     <= '0;
      fifo_level                 <= '0;
      n_words                    <= '0;
      word_cnt                   <= '0;
      byte_idx                   <= '0;
      flush_cnt                  <= '0;
      pkt_count                  <= '0;
      tx_udp_length              <= '0;
      tx_udp_hdr_valid           <= 1'b0;
      tx_udp_payload_axis_tvalid <= 1'b0;
      tx_udp_payload_axis_tdata  <= '0;
      tx_udp_payload_axis_tlast  <= 1'b0;
    end else begin
      tx_udp_hdr_valid           <= hdr_valid_d;
      tx_udp_payload_axis_tvalid <= tvalid_d;
      tx_udp_payload_axis_tdata  <= tdata_d;
      tx_udp_payload_axis_tlast  <= tlast_d;

      if (wr_en) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      case ({wr_en, pop})
        2'b10:   fifo_level <= fifo_level + 1'b1;
        2'b01:   fifo_level <= fifo_level - 1'b1;
        default: fifo_level <= fifo_level;
      endcase

      // Packet size is frozen here; later writes only grow the FIFO.
      if (start) begin
        n_words       <= n_start;
        tx_udp_length <= 16'd8 + (16'(n_start) << 2);
      end

      if (state == HDR) begin
        word_cnt <= '0;
        byte_idx <= '0;
      end else if (hs) begin
        byte_idx <= byte_idx + 1'b1;
        if (byte_idx == 2'd3) word_cnt <= word_cnt + 1'b1;
      end

      if (last_hs) pkt_count <= pkt_count + 1'b1;

      if (state != IDLE || wr_en || !partial) flush_cnt <= '0;
      else if (!flush_exp)                    flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_udp_word_tx.sv
// Directed bench for udp_word_tx: table-driven full packets plus hand-written
// flush, stall, backpressure, simultaneous write/pop and reset sequences.
module tb_udp_word_tx;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_ready;
  logic        hdr_valid;
  logic        hdr_ready;
  logic [15:0] udp_length;
  logic [7:0]  tdata;
  logic        tvalid;
  logic        tready;
  logic        tlast;
  logic [4:0]  fifo_level;
  logic [15:0] pkt_count;

  always #4 clk = ~clk;

  udp_word_tx dut (
    .clk                        (clk),
    .rst                        (rst),
    .in_data                    (in_data),
    .in_valid                   (in_valid),
    .in_ready                   (in_ready),
    .tx_udp_hdr_valid           (hdr_valid),
    .tx_udp_hdr_ready           (hdr_ready),
    .tx_udp_length              (udp_length),
    .tx_udp_payload_axis_tdata  (tdata),
    .tx_udp_payload_axis_tvalid (tvalid),
    .tx_udp_payload_axis_tready (tready),
    .tx_udp_payload_axis_tlast  (tlast),
    .fifo_level                 (fifo_level),
    .pkt_count                  (pkt_count)
  );

  typedef struct {
    logic [31:0] word;
    logic [7:0]  b0, b1, b2, b3;
  } vec_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  logic [7:0]  byte_q[$];
  logic        last_q[$];
  logic [15:0] hdr_q[$];
  logic [7:0]  exp_b[$];
  logic        exp_l[$];
  logic [15:0] exp_h[$];
  int          tv_cycles = 0;
  logic        stall_pend = 1'b0;
  logic [7:0]  held_d;
  logic        held_l;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Bus monitor on the falling edge: whatever is valid+ready here is the
  // handshake of the next rising edge.
  always @(negedge clk) begin
    if (tvalid) tv_cycles++;
    if (stall_pend && tvalid) begin
      check("stall_tdata", tdata, held_d);
      check("stall_tlast", tlast, held_l);
    end
    stall_pend = tvalid && !tready;
    held_d     = tdata;
    held_l     = tlast;
    if (tvalid && tready) begin
      byte_q.push_back(tdata);
      last_q.push_back(tlast);
    end
    if (hdr_valid && hdr_ready) hdr_q.push_back(udp_length);
  end

  task automatic push(input logic [31:0] d);
    int t = 0;
    in_data  = d;
    in_valid = 1'b1;
    while (!in_ready && t < 2000) begin
      @(posedge clk); #1;
      t++;
    end
    if (t >= 2000) check("push_timeout", in_ready, 1'b1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_pkt(input logic [15:0] target, input bit toggle);
    int t = 0;
    while (pkt_count != target && t < 3000) begin
      @(posedge clk); #1;
      if (toggle) tready = ~tready;
      t++;
    end
    tready = 1'b1;
    check("pkt_count", pkt_count, target);
  endtask

  task automatic expect_word(input logic [31:0] w, input bit last);
    exp_b.push_back(w[31:24]);
    exp_b.push_back(w[23:16]);
    exp_b.push_back(w[15:8]);
    exp_b.push_back(w[7:0]);
    repeat (3) exp_l.push_back(1'b0);
    exp_l.push_back(last);
  endtask

  task automatic compare_stream(input string name);
    check({name, "_nbytes"}, byte_q.size(), exp_b.size());
    for (int i = 0; i < exp_b.size() && i < byte_q.size(); i++) begin
      check({name, "_byte"}, byte_q[i], exp_b[i]);
      check({name, "_tlast"}, last_q[i], exp_l[i]);
    end
    check({name, "_nhdr"}, hdr_q.size(), exp_h.size());
    for (int i = 0; i < exp_h.size() && i < hdr_q.size(); i++)
      check({name, "_length"}, hdr_q[i], exp_h[i]);
    byte_q.delete(); last_q.delete(); hdr_q.delete();
    exp_b.delete();  exp_l.delete();  exp_h.delete();
  endtask

  initial begin
    vec_t tbl[8];
    int   cnt;
    tbl[0] = '{32'h01020304, 8'h01, 8'h02, 8'h03, 8'h04};
    tbl[1] = '{32'h05060708, 8'h05, 8'h06, 8'h07, 8'h08};
    tbl[2] = '{32'h090A0B0C, 8'h09, 8'h0A, 8'h0B, 8'h0C};
    tbl[3] = '{32'h0D0E0F10, 8'h0D, 8'h0E, 8'h0F, 8'h10};
    tbl[4] = '{32'hA1B2C3D4, 8'hA1, 8'hB2, 8'hC3, 8'hD4};
    tbl[5] = '{32'h00FF7F80, 8'h00, 8'hFF, 8'h7F, 8'h80};
    tbl[6] = '{32'hFFFFFFFF, 8'hFF, 8'hFF, 8'hFF, 8'hFF};
    tbl[7] = '{32'h80000001, 8'h80, 8'h00, 8'h00, 8'h01};

    rst = 1'b1; in_valid = 1'b0; in_data = '0; tready = 1'b1; hdr_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hdr_valid", hdr_valid, 1'b0);
    check("rst_tvalid", tvalid, 1'b0);
    check("rst_tlast", tlast, 1'b0);
    check("rst_tdata", tdata, 8'h00);
    check("rst_length", udp_length, 16'h0000);
    check("rst_fifo_level", fifo_level, 5'd0);
    check("rst_pkt_count", pkt_count, 16'd0);
    check("rst_in_ready", in_ready, 1'b1);
    rst = 1'b0;
    @(posedge clk); #1;

    // Two full packets from the vector table.
    for (int g = 0; g < 2; g++) begin
      tv_cycles = 0;
      for (int k = 0; k < 4; k++) push(tbl[4*g + k].word);
      wait_pkt(16'(g + 1), 1'b0);
      for (int k = 0; k < 4; k++) begin
        exp_b.push_back(tbl[4*g + k].b0);
        exp_b.push_back(tbl[4*g + k].b1);
        exp_b.push_back(tbl[4*g + k].b2);
        exp_b.push_back(tbl[4*g + k].b3);
        exp_l.push_back(1'b0); exp_l.push_back(1'b0); exp_l.push_back(1'b0);
        exp_l.push_back(k == 3);
      end
      exp_h.push_back(16'h0018);
      compare_stream("full_pkt");
      if (g == 0) check("full_payload_cycles", tv_cycles, 16);
      check("full_level_after", fifo_level, 5'd0);
    end

    // Flush of a single word after 1250 idle cycles.
    push(32'hDEADBEEF);
    cnt = 0;
    while (!hdr_valid && cnt < 3000) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("flush_latency", cnt, 1250);
    wait_pkt(16'd3, 1'b0);
    expect_word(32'hDEADBEEF, 1'b1);
    exp_h.push_back(16'h000C);
    compare_stream("flush_pkt");

    // tready toggling every cycle during a 4-word packet.
    for (int k = 0; k < 4; k++) push(32'h31323334 + 32'(k) * 32'h04040404);
    wait_pkt(16'd4, 1'b1);
    for (int k = 0; k < 4; k++) expect_word(32'h31323334 + 32'(k) * 32'h04040404, k == 3);
    exp_h.push_back(16'h0018);
    compare_stream("toggle_pkt");

    // Fill the FIFO behind a stalled header, then release.
    hdr_ready = 1'b0;
    for (int k = 0; k < 16; k++) push(32'h40000000 + 32'(k));
    check("full_level", fifo_level, 5'd16);
    check("full_in_ready", in_ready, 1'b0);
    check("stalled_hdr_valid", hdr_valid, 1'b1);
    check("stalled_length", udp_length, 16'h0018);
    hdr_ready = 1'b1;
    cnt = 0;
    while (!in_ready && cnt < 100) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("first_pop_in_ready", in_ready, 1'b1);
    check("first_pop_level", fifo_level, 5'd15);
    wait_pkt(16'd8, 1'b0);
    for (int p = 0; p < 4; p++) begin
      for (int k = 0; k < 4; k++) expect_word(32'h40000000 + 32'(4*p + k), k == 3);
      exp_h.push_back(16'h0018);
    end
    compare_stream("burst_pkts");
    check("burst_level_after", fifo_level, 5'd0);

    // Write on the same edge as the pop of the first word.
    for (int k = 0; k < 4; k++) push(32'h11121314 + 32'(k) * 32'h04040404);
    cnt = 0;
    while (!(tvalid && tdata == 8'h14) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("sim_wr_pop_level_before", fifo_level, 5'd4);
    in_data = 32'h55667788; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    check("sim_wr_pop_level", fifo_level, 5'd4);
    wait_pkt(16'd9, 1'b0);
    for (int k = 0; k < 4; k++) expect_word(32'h11121314 + 32'(k) * 32'h04040404, k == 3);
    exp_h.push_back(16'h0018);
    compare_stream("sim_wr_pop_pkt");
    check("sim_wr_pop_leftover", fifo_level, 5'd1);
    wait_pkt(16'd10, 1'b0);
    expect_word(32'h55667788, 1'b1);
    exp_h.push_back(16'h000C);
    compare_stream("sim_wr_pop_next");

    // Reset on the 6th payload byte.
    for (int k = 0; k < 4; k++) push(32'h21222324 + 32'(k) * 32'h04040404);
    cnt = 0;
    while (!(tvalid && tdata == 8'h26) && cnt < 200) begin
      @(posedge clk); #1;
      cnt++;
    end
    check("rst6_reached", tdata, 8'h26);
    rst = 1'b1;
    @(posedge clk); #1;
    check("rst6_tvalid", tvalid, 1'b0);
    check("rst6_tlast", tlast, 1'b0);
    check("rst6_level", fifo_level, 5'd0);
    check("rst6_pkt_count", pkt_count, 16'd0);
    rst = 1'b0;
    @(posedge clk); #1;
    byte_q.delete(); last_q.delete(); hdr_q.delete();
    for (int k = 0; k < 4; k++) push(32'hC0C1C2C3 + 32'(k) * 32'h04040404);
    wait_pkt(16'd1, 1'b0);
    for (int k = 0; k < 4; k++) expect_word(32'hC0C1C2C3 + 32'(k) * 32'h04040404, k == 3);
    exp_h.push_back(16'h0018);
    compare_stream("post_rst_pkt");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
